// File: rtl/segre_pkg.sv
`default_nettype none
// ============================================================================
// Module   : segre_pkg
// Brief    : Shared types and constants for the segre core front end.
// Revision : 1.0 - decoupled fetch unit support
// ============================================================================
package segre_pkg;

    localparam int          XLEN                = 32;
    localparam int          FQ_DEPTH_DEF        = 4;
    localparam int          MAX_OUTSTANDING_DEF = 2;
    localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;

    // One fetched instruction together with the address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/segre_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : segre_fetch_if
// Brief    : Memory-side req/gnt/response bus, redirect input and decode-side
//            valid/ready bus of the fetch unit.
// Revision : 1.0 - initial
// ============================================================================
interface segre_fetch_if
    import segre_pkg::*;
#(
    parameter int ADDR_W     = XLEN,
    parameter int LINE_BYTES = 16
) ();

    logic                    mem_req_o;
    logic [ADDR_W-1:0]       mem_addr_o;
    logic                    mem_gnt_i;
    logic                    mem_rsp_valid_i;
    logic [LINE_BYTES*8-1:0] mem_rsp_line_i;
    logic                    redirect_i;
    logic [ADDR_W-1:0]       redirect_pc_i;
    logic                    instr_valid_o;
    logic                    instr_ready_i;
    logic [31:0]             instr_o;
    logic [ADDR_W-1:0]       pc_o;
    logic                    waiting_mem_req_o;

    // Fetch unit side
    modport master (
        output mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_o, waiting_mem_req_o,
        input  mem_gnt_i, mem_rsp_valid_i, mem_rsp_line_i, redirect_i, redirect_pc_i,
               instr_ready_i
    );

    // Memory / decode / writeback side
    modport slave (
        input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_o, waiting_mem_req_o,
        output mem_gnt_i, mem_rsp_valid_i, mem_rsp_line_i, redirect_i, redirect_pc_i,
               instr_ready_i
    );

endinterface
`default_nettype wire

// File: rtl/segre_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : segre_fetch_queue
// Brief    : Small synchronous FIFO with flush. Circular indices carry an
//            extra wrap bit so full and empty are told apart without a
//            separate counter. A push into a full queue is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0 - initial
// ============================================================================
module segre_fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk_i,
    input  wire logic                       rst_i,
    input  wire logic                       push_i,
    input  wire logic [WIDTH-1:0]           data_i,
    input  wire logic                       pop_i,
    input  wire logic                       flush_i,
    output logic      [WIDTH-1:0]           data_o,
    output logic      [$clog2(DEPTH+1)-1:0] count_o,
    output logic                            empty_o,
    output logic                            full_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic             r_wr_wrap;
    logic             r_rd_wrap;
    logic             w_push;
    logic             w_pop;
    int               w_count;

    assign empty_o = (r_wr_idx == r_rd_idx) && (r_wr_wrap == r_rd_wrap);
    assign full_o  = (r_wr_idx == r_rd_idx) && (r_wr_wrap != r_rd_wrap);
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign data_o  = r_mem[r_rd_idx];
    assign count_o = CNT_W'(w_count);

    // Occupancy from the index distance; differing wrap bits mean the writer lapped
    always_comb begin
        w_count = 0;
        if (r_wr_wrap == r_rd_wrap) begin
            w_count = int'(r_wr_idx) - int'(r_rd_idx);
        end else begin
            w_count = DEPTH + int'(r_wr_idx) - int'(r_rd_idx);
        end
    end

    // Storage needs no reset: entries are only observed while counted as valid
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_idx] <= data_i;
        end
    end

    // Index/wrap update; flush empties the queue and overrides push and pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_wr_wrap <= 1'b0;
            r_rd_wrap <= 1'b0;
        end else if (flush_i) begin
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_wr_wrap <= 1'b0;
            r_rd_wrap <= 1'b0;
        end else begin
            if (w_push) begin
                if (r_wr_idx == IDX_W'(DEPTH - 1)) begin
                    r_wr_idx  <= '0;
                    r_wr_wrap <= ~r_wr_wrap;
                end else begin
                    r_wr_idx  <= r_wr_idx + 1'b1;
                end
            end
            if (w_pop) begin
                if (r_rd_idx == IDX_W'(DEPTH - 1)) begin
                    r_rd_idx  <= '0;
                    r_rd_wrap <= ~r_rd_wrap;
                end else begin
                    r_rd_idx  <= r_rd_idx + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/segre_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : segre_fetch_unit
// Brief    : Decoupled pipelined instruction fetch. Issues up to
//            MAX_OUTSTANDING in-order line requests, extracts the addressed
//            word from each response into a fetch queue feeding decode, and
//            squashes queued and in-flight work on a redirect.
// Revision : 1.0 - replaces the single-request FSM fetch stage
// ============================================================================
module segre_fetch_unit
    import segre_pkg::*;
#(
    parameter int                ADDR_W          = XLEN,
    parameter int                LINE_BYTES      = 16,
    parameter int                FQ_DEPTH        = FQ_DEPTH_DEF,
    parameter int                MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
    input wire logic      clk_i,
    input wire logic      rst_i,
    segre_fetch_if.master bus
);

    localparam int                OFF_W    = $clog2(LINE_BYTES);
    localparam int                OS_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int                FQ_CNT_W = $clog2(FQ_DEPTH + 1);
    localparam int                ENTRY_W  = ADDR_W + 32;
    localparam logic [ADDR_W-1:0] PC_MASK  = ~ADDR_W'(3);

    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [OS_W-1:0]     r_drop_cnt;

    logic                w_req;
    logic                w_grant;
    logic                w_rsp;
    logic                w_drop;
    logic [ADDR_W-1:0]   w_redirect_pc;
    logic [ADDR_W-1:0]   w_rsp_addr;
    logic [31:0]         w_rsp_word;
    logic [OS_W-1:0]     w_pa_cnt;
    logic                w_pa_empty;
    logic                w_pa_full;
    logic                w_fq_push;
    logic                w_fq_pop;
    logic                w_fq_empty;
    logic                w_fq_full;
    logic [FQ_CNT_W-1:0] w_fq_cnt;
    logic [ENTRY_W-1:0]  w_fq_head;
    logic                w_valid;

    // The pending-address FIFO count is the number of granted, unanswered requests.
    // Issue credit counts those as already occupying the fetch queue, so every
    // response always finds room.
    assign w_req = !bus.redirect_i && !w_pa_full && !w_fq_full &&
                   ((int'(w_pa_cnt) + int'(w_fq_cnt)) < FQ_DEPTH);
    assign w_grant       = w_req && bus.mem_gnt_i;
    assign w_rsp         = bus.mem_rsp_valid_i;
    assign w_drop        = (r_drop_cnt != '0);
    assign w_redirect_pc = bus.redirect_pc_i & PC_MASK;

    // Responses arrive in request order, so the oldest pending address owns them
    segre_fetch_queue #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend_addr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_grant),
        .data_i  (r_fetch_pc),
        .pop_i   (w_rsp),
        .flush_i (1'b0),
        .data_o  (w_rsp_addr),
        .count_o (w_pa_cnt),
        .empty_o (w_pa_empty),
        .full_o  (w_pa_full)
    );

    generate
        if (LINE_BYTES == 4) begin : g_word_whole_line
            assign w_rsp_word = bus.mem_rsp_line_i;
        end else begin : g_word_select
            logic [OFF_W-3:0] w_word_idx;
            assign w_word_idx = w_rsp_addr[OFF_W-1:2];
            assign w_rsp_word = bus.mem_rsp_line_i[{w_word_idx, 5'b0} +: 32];
        end
    endgenerate

    // A redirect flushes through the queue's flush, which also blocks the push
    assign w_valid   = !w_fq_empty && !bus.redirect_i;
    assign w_fq_push = w_rsp && !w_drop;
    assign w_fq_pop  = w_valid && bus.instr_ready_i;

    segre_fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_fq_push),
        .data_i  ({w_rsp_addr, w_rsp_word}),
        .pop_i   (w_fq_pop),
        .flush_i (bus.redirect_i),
        .data_o  (w_fq_head),
        .count_o (w_fq_cnt),
        .empty_o (w_fq_empty),
        .full_o  (w_fq_full)
    );

    // Fetch PC: redirect target wins, otherwise advance one word per grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC & PC_MASK;
        end else if (bus.redirect_i) begin
            r_fetch_pc <= w_redirect_pc;
        end else if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        end
    end

    // Stale-response counter: everything in flight at a redirect is squashed,
    // except a response landing in the redirect cycle, which is dropped directly
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_drop_cnt <= '0;
        end else if (bus.redirect_i) begin
            r_drop_cnt <= w_pa_cnt - OS_W'(w_rsp);
        end else if (w_rsp && w_drop) begin
            r_drop_cnt <= r_drop_cnt - OS_W'(1);
        end
    end

    assign bus.mem_req_o         = w_req && !rst_i;
    assign bus.mem_addr_o        = rst_i ? '0 : r_fetch_pc;
    assign bus.instr_valid_o     = w_valid && !rst_i;
    assign bus.instr_o           = (rst_i || w_fq_empty) ? '0 : w_fq_head[31:0];
    assign bus.pc_o              = (rst_i || w_fq_empty) ? '0 : w_fq_head[ENTRY_W-1:32];
    assign bus.waiting_mem_req_o = !rst_i && !w_pa_empty && w_fq_empty;

endmodule
`default_nettype wire
